// File: rtl/seq_csa_multiplier.sv
// +----------------------------------------------------------------------------+
// | seq_csa_multiplier                                                         |
// | Multi-cycle RV32M multiplier: carry-save accumulation, then one CPA.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seq_csa_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         mulop,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result
);

  localparam int c_ncyc  = WIDTH / BITS_PER_CYCLE;
  localparam int c_cnt_w = $clog2(c_ncyc + 1);
  localparam int c_pw    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_mulop;
  logic               r_neg;
  logic [c_cnt_w-1:0] r_count;
  logic [c_pw-1:0]    r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_pw-1:0]    r_sum;
  logic [c_pw-1:0]    r_carry;
  logic [c_pw-1:0]    r_product;
  logic [WIDTH-1:0]   r_result;

  // Operand conditioning: magnitudes plus a single sign for the final fix-up
  logic             w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg, w_accept;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_a_sgn  = (mulop != 2'b11);
  assign w_b_sgn  = ~mulop[1];
  assign w_a_neg  = w_a_sgn & a[WIDTH-1];
  assign w_b_neg  = w_b_sgn & b[WIDTH-1];
  assign w_neg    = w_a_neg ^ w_b_neg;
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;
  assign w_accept = start & ~flush;

  // Chain of 3:2 compressors folding each gated partial product into sum/carry
  logic [c_pw-1:0] w_s [BITS_PER_CYCLE+1];
  logic [c_pw-1:0] w_c [BITS_PER_CYCLE+1];

  assign w_s[0] = r_sum;
  assign w_c[0] = r_carry;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_csa
    logic [c_pw-1:0] w_pp;
    logic [c_pw-1:0] w_maj;
    assign w_pp     = r_mplier[i] ? (r_mcand << i) : '0;
    assign w_maj    = (w_s[i] & w_c[i]) | (w_s[i] & w_pp) | (w_c[i] & w_pp);
    assign w_s[i+1] = w_s[i] ^ w_c[i] ^ w_pp;
    assign w_c[i+1] = {w_maj[c_pw-2:0], 1'b0};
  end

  logic [c_pw-1:0] w_p, w_prod;
  assign w_p    = r_sum + r_carry;
  assign w_prod = r_neg ? -w_p : w_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM:   if (flush) w_state_nxt = S_IDLE;
                 else if (r_count == c_cnt_w'(1)) w_state_nxt = S_RESOLVE;
      S_RESOLVE: w_state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mulop   <= '0;
      r_neg     <= 1'b0;
      r_count   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_product <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_mulop  <= mulop;
          r_neg    <= w_neg;
          r_count  <= c_cnt_w'(c_ncyc);
          r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
          r_mplier <= w_b_abs;
          r_sum    <= '0;
          r_carry  <= '0;
        end
        S_ACCUM: if (!flush) begin
          r_sum    <= w_s[BITS_PER_CYCLE];
          r_carry  <= w_c[BITS_PER_CYCLE];
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_count  <= r_count - 1'b1;
        end
        // A squash here must leave the previously committed result visible
        S_RESOLVE: if (!flush) begin
          r_product <= w_prod;
          r_result  <= (r_mulop == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[c_pw-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
  assign result  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_csa_multiplier.sv
// +----------------------------------------------------------------------------+
// | tb_seq_csa_multiplier                                                      |
// | Directed and randomised checks of seq_csa_multiplier at 1/2/4/8 bits/cycle.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_seq_csa_multiplier;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  op_mul;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start_v   [4];
  logic        ready_v   [4];
  logic        done_v    [4];
  logic [63:0] product_v [4];
  logic [31:0] result_v  [4];

  int n_cmp = 0;
  int n_err = 0;

  // Instance k retires 2**k multiplier bits per cycle; index 2 is the default build
  for (genvar k = 0; k < 4; k++) begin : g_dut
    seq_csa_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1 << k)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_v[k]),
      .flush   (flush),
      .mulop   (op_mul),
      .a       (op_a),
      .b       (op_b),
      .ready   (ready_v[k]),
      .done    (done_v[k]),
      .product (product_v[k]),
      .result  (result_v[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy;
    sx = (op != 2'b11) ? {{32{x[31]}}, x} : {32'b0, x};
    sy = (op[1] == 1'b0) ? {{32{y[31]}}, y} : {32'b0, y};
    return sx * sy;
  endfunction

  function automatic logic [63:0] res_of(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'b00) ? {32'b0, p[31:0]} : {32'b0, p[63:32]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Accepts one op on instance k, scrambles the inputs, waits (bounded) for done
  task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, output int lat);
    @(negedge clk);
    op_mul = op; op_a = x; op_b = y; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0; op_a = $urandom; op_b = $urandom; op_mul = 2'($urandom);
    lat = 1;
    while (!done_v[k] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [63:0] exp_p;
    logic [1:0]  cur_op;

    rst = 1'b1; flush = 1'b0; op_mul = '0; op_a = '0; op_b = '0;
    for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
    #3;
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", 64'(ready_v[k]), 64'd1);
      check("rst_done", 64'(done_v[k]), 64'd0);
      check("rst_product", product_v[k], 64'd0);
      check("rst_result", 64'(result_v[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // MULHU all-ones squared, with exact latency and single-cycle done
    run_op(2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mulhu_lat", 64'(lat), 64'd10);
    check("mulhu_prod", product_v[2], 64'hFFFF_FFFE_0000_0001);
    check("mulhu_res", 64'(result_v[2]), 64'hFFFF_FFFE);
    check("done_ready_low", 64'(ready_v[2]), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done_v[2]), 64'd0);
    check("idle_ready", 64'(ready_v[2]), 64'd1);

    run_op(2, 2'b01, 32'h8000_0000, 32'h8000_0000, lat);
    check("mulh_minmin_prod", product_v[2], 64'h4000_0000_0000_0000);
    check("mulh_minmin_res", 64'(result_v[2]), 64'h4000_0000);
    run_op(2, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, lat);
    check("mul_neg_prod", product_v[2], 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_neg_res", 64'(result_v[2]), 64'hFFFF_FFEB);

    run_op(2, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mulhsu_prod", product_v[2], 64'hFFFF_FFFF_0000_0001);
    check("mulhsu_res", 64'(result_v[2]), 64'hFFFF_FFFF);

    // Squash in the fourth ACCUM cycle
    @(negedge clk);
    op_mul = 2'b11; op_a = 32'h1234_5678; op_b = 32'h9; start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 64'(ready_v[2]), 64'd1);
    check("flush_done", 64'(done_v[2]), 64'd0);
    check("flush_prod_kept", product_v[2], 64'hFFFF_FFFF_0000_0001);
    check("flush_res_kept", 64'(result_v[2]), 64'hFFFF_FFFF);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done_v[2]) cnt++; end
    check("flush_no_done", 64'(cnt), 64'd0);
    run_op(2, 2'b11, 32'd3, 32'd5, lat);
    check("after_flush_lat", 64'(lat), 64'd10);
    check("after_flush_prod", product_v[2], 64'd15);
    check("after_flush_res", 64'(result_v[2]), 64'd0);

    // flush together with start in IDLE: the request is dropped
    @(negedge clk);
    op_mul = 2'b11; op_a = 32'd5; op_b = 32'd5; start_v[2] = 1'b1; flush = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0; flush = 1'b0;
    check("flush_start_ready", 64'(ready_v[2]), 64'd1);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done_v[2]) cnt++; end
    check("flush_start_no_done", 64'(cnt), 64'd0);
    check("flush_start_prod", product_v[2], 64'd15);

    // start held high with garbage operands throughout the busy period
    @(negedge clk);
    op_mul = 2'b01; op_a = 32'hFFFF_0000; op_b = 32'h0002_0000; start_v[2] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      op_a = $urandom; op_b = $urandom; op_mul = 2'($urandom);
    end while (!done_v[2] && lat < 60);
    start_v[2] = 1'b0;
    check("busy_start_lat", 64'(lat), 64'd10);
    check("busy_start_prod", product_v[2], 64'hFFFF_FFFE_0000_0000);
    check("busy_start_res", 64'(result_v[2]), 64'hFFFF_FFFE);

    // Asynchronous reset in the middle of ACCUM, observed between clock edges
    @(negedge clk);
    op_mul = 2'b11; op_a = 32'd2; op_b = 32'd3; start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_arst_ready", 64'(ready_v[2]), 64'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", 64'(ready_v[2]), 64'd1);
    check("arst_done", 64'(done_v[2]), 64'd0);
    check("arst_prod", product_v[2], 64'd0);
    check("arst_res", 64'(result_v[2]), 64'd0);
    #1 rst = 1'b0;

    // All four bit-per-cycle builds on the same random operands
    for (int it = 0; it < 200; it++) begin
      logic [3:0]  seen;
      int          got_lat [4];
      logic [63:0] got_p   [4];
      logic [31:0] got_r   [4];
      @(negedge clk);
      cur_op = 2'($urandom_range(0, 3));
      op_mul = cur_op; op_a = pick(); op_b = pick();
      exp_p = model(cur_op, op_a, op_b);
      for (int k = 0; k < 4; k++) begin
        start_v[k] = 1'b1; got_lat[k] = 0; got_p[k] = '0; got_r[k] = '0;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
      op_a = $urandom; op_b = $urandom;
      seen = '0; lat = 1;
      while (seen != 4'hF && lat < 60) begin
        for (int k = 0; k < 4; k++)
          if (done_v[k] && !seen[k]) begin
            seen[k] = 1'b1; got_lat[k] = lat; got_p[k] = product_v[k]; got_r[k] = result_v[k];
          end
        if (seen != 4'hF) begin @(negedge clk); lat++; end
      end
      for (int k = 0; k < 4; k++) begin
        check("rand_lat", 64'(got_lat[k]), 64'((32 >> k) + 2));
        check("rand_prod", got_p[k], exp_p);
        check("rand_res", 64'(got_r[k]), res_of(cur_op, exp_p));
      end
    end

    // Back-to-back ops at full throughput on the default build
    @(negedge clk);
    cur_op = 2'($urandom_range(0, 3));
    op_mul = cur_op; op_a = pick(); op_b = pick();
    exp_p = model(cur_op, op_a, op_b);
    start_v[2] = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done_v[2] && lat < 60);
      check("b2b_period", 64'(lat), (it == 0) ? 64'd10 : 64'd11);
      check("b2b_prod", product_v[2], exp_p);
      check("b2b_res", 64'(result_v[2]), res_of(cur_op, exp_p));
      cur_op = 2'($urandom_range(0, 3));
      op_mul = cur_op; op_a = pick(); op_b = pick();
      exp_p = model(cur_op, op_a, op_b);
    end
    start_v[2] = 1'b0;
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
